// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing and types; reservation stations use the same IDX_W tags.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int IDX_W     = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;
    localparam int NUM_SRC   = 2;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [4:0]      rd;
        logic [XLEN-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  value;
    } cdb_t;

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Combinational operand read by ROB tag, with same-cycle CDB bypass.
module rob_lookup_port
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_DEPTH-1:0]           busy,
    input  logic [ROB_DEPTH-1:0]           done,
    input  logic [ROB_DEPTH-1:0][XLEN-1:0] value_arr,
    input  cdb_t                           cdb,
    input  logic [IDX_W-1:0]               idx,
    output logic                           ready,
    output logic [XLEN-1:0]                value
);

    logic hit;

    assign hit   = cdb.valid && (cdb.idx == idx);
    // a broadcast only counts for an entry that is actually in flight
    assign ready = busy[idx] && (done[idx] || hit);
    assign value = hit ? cdb.value : value_arr[idx];

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags issued at dispatch, CDB capture, in-order retire.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             alloc_valid_in,
    input  logic [4:0]       alloc_rd_in,
    output logic             alloc_ready_out,
    output logic [IDX_W-1:0] alloc_idx_out,
    input  logic             cdb_valid_in,
    input  logic [IDX_W-1:0] cdb_idx_in,
    input  logic [XLEN-1:0]  cdb_value_in,
    input  logic [IDX_W-1:0] src1_idx_in,
    input  logic [IDX_W-1:0] src2_idx_in,
    output logic             src1_ready_out,
    output logic [XLEN-1:0]  src1_value_out,
    output logic             src2_ready_out,
    output logic [XLEN-1:0]  src2_value_out,
    output logic             commit_valid_out,
    input  logic             commit_ready_in,
    output logic [4:0]       commit_rd_out,
    output logic [XLEN-1:0]  commit_value_out,
    output logic [IDX_W-1:0] commit_idx_out,
    output logic [IDX_W:0]   count_out,
    output logic             empty_out
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    rob_entry_t [ROB_DEPTH-1:0]           ent_q;
    logic [IDX_W-1:0]                     head_q, tail_q;
    logic [IDX_W:0]                       count_q;
    logic                                 alloc_fire, wb_fire, commit_fire;
    cdb_t                                 cdb;
    logic [ROB_DEPTH-1:0]                 busy_vec, done_vec;
    logic [ROB_DEPTH-1:0][XLEN-1:0]       value_vec;
    logic [NUM_SRC-1:0][IDX_W-1:0]        src_idx;
    logic [NUM_SRC-1:0]                   src_ready;
    logic [NUM_SRC-1:0][XLEN-1:0]         src_value;

    assign cdb = '{valid: cdb_valid_in, idx: cdb_idx_in, value: cdb_value_in};

    // ready looks only at registered count, so a full buffer stays full for
    // one cycle even when the head retires, and commit_ready_in never reaches it
    assign alloc_ready_out  = (count_q < FULL_CNT);
    assign alloc_fire       = alloc_valid_in && alloc_ready_out;
    assign wb_fire          = cdb_valid_in && ent_q[cdb_idx_in].busy;
    assign commit_valid_out = ent_q[head_q].busy && ent_q[head_q].done;
    assign commit_fire      = commit_valid_out && commit_ready_in;

    assign alloc_idx_out    = tail_q;
    assign commit_rd_out    = ent_q[head_q].rd;
    assign commit_value_out = ent_q[head_q].value;
    assign commit_idx_out   = head_q;
    assign count_out        = count_q;
    assign empty_out        = (count_q == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_in || flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i].busy <= 1'b0;
                ent_q[i].done <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (alloc_fire && (tail_q == IDX_W'(i))) begin
                    ent_q[i].busy <= 1'b1;
                    ent_q[i].done <= 1'b0;
                    ent_q[i].rd   <= alloc_rd_in;
                end
                if (wb_fire && (cdb_idx_in == IDX_W'(i))) begin
                    ent_q[i].done  <= 1'b1;
                    ent_q[i].value <= cdb_value_in;
                end
                // tail==head with both firing needs a full buffer, which blocks alloc
                if (commit_fire && (head_q == IDX_W'(i))) begin
                    ent_q[i].busy <= 1'b0;
                    ent_q[i].done <= 1'b0;
                end
            end
            head_q  <= head_q + IDX_W'(commit_fire);
            tail_q  <= tail_q + IDX_W'(alloc_fire);
            count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
        end
    end

    for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_flat
        assign busy_vec[g]  = ent_q[g].busy;
        assign done_vec[g]  = ent_q[g].done;
        assign value_vec[g] = ent_q[g].value;
    end

    assign src_idx = {src2_idx_in, src1_idx_in};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        rob_lookup_port u_lookup (
            .busy      (busy_vec),
            .done      (done_vec),
            .value_arr (value_vec),
            .cdb       (cdb),
            .idx       (src_idx[s]),
            .ready     (src_ready[s]),
            .value     (src_value[s])
        );
    end

    assign src1_ready_out = src_ready[0];
    assign src1_value_out = src_value[0];
    assign src2_ready_out = src_ready[1];
    assign src2_value_out = src_value[1];

endmodule
